// File: rtl/ex_wb_regfile_pkg.sv
// Shared widths and constants for the EX write-back stage and register file.
// Consumed by ex_wb_regfile and its read ports.
package ex_wb_regfile_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = $clog2(NREGS);

    localparam logic [XLEN-1:0] ZERO32     = '0;
    localparam logic            RST_ENABLE = 1'b1;

    typedef logic [XLEN-1:0]      data_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/ex_wb_regfile_read_port.sv
// One combinational source-operand port: x0 and disabled reads give zero.
// REGFILE_BYPASS_EN forwards the pending write-back entry on an index match.
module ex_wb_regfile_read_port
    import ex_wb_regfile_pkg::*;
#(
    parameter int DATA_W  = XLEN,
    parameter int REG_NUM = NREGS,
    parameter int IDX_W   = REG_IDX_W
) (
    input  logic              rs_e,
    input  logic [IDX_W-1:0]  rs_idx,
    input  logic [DATA_W-1:0] regs [REG_NUM],
`ifdef REGFILE_BYPASS_EN
    input  logic              wb_e,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_data,
`endif
    output logic [DATA_W-1:0] rs_data
);

    logic zero_sel;
    logic hit_sel;

    assign zero_sel = !rs_e || (rs_idx == '0);

`ifdef REGFILE_BYPASS_EN
    assign hit_sel = !zero_sel && wb_e && (wb_idx == rs_idx);
`else
    assign hit_sel = 1'b0;
`endif

    always_comb begin
        rs_data = '0;
        unique case (1'b1)
            zero_sel: rs_data = '0;
`ifdef REGFILE_BYPASS_EN
            hit_sel:  rs_data = wb_data;
`endif
            default:  rs_data = hit_sel ? '0 : regs[rs_idx];
        endcase
    end

endmodule

// File: rtl/ex_wb_regfile.sv
// EX result write-back stage register plus 32x32 integer register file.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module ex_wb_regfile
    import ex_wb_regfile_pkg::*;
#(
    parameter int DATA_W  = XLEN,
    parameter int REG_NUM = NREGS,
    parameter int IDX_W   = REG_IDX_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              rdE_in,
    input  logic [IDX_W-1:0]  rdIdx_in,
    input  logic [DATA_W-1:0] rdData_in,
    input  logic              rs1E_in,
    input  logic [IDX_W-1:0]  rs1Idx_in,
    input  logic              rs2E_in,
    input  logic [IDX_W-1:0]  rs2Idx_in,
    output logic [DATA_W-1:0] rs1Data_out,
    output logic [DATA_W-1:0] rs2Data_out,
    output logic              wbE_out,
    output logic [IDX_W-1:0]  wbIdx_out,
    output logic [DATA_W-1:0] wbData_out
);

    logic              wb_e;
    logic [IDX_W-1:0]  wb_idx;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] regs [REG_NUM];

    // The pending entry commits on the same edge the stage reloads, so
    // flush/stall only affect what is latched next, never the commit.
    always_ff @(posedge clk_in) begin
        if (rst_in == RST_ENABLE) begin
            wb_e    <= 1'b0;
            wb_idx  <= '0;
            wb_data <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wb_e && (wb_idx != '0)) begin
                regs[wb_idx] <= wb_data;
            end
            if (flush_in) begin
                wb_e <= 1'b0;
            end else if (!stall_in) begin
                wb_e    <= rdE_in && (rdIdx_in != '0);
                wb_idx  <= rdIdx_in;
                wb_data <= rdData_in;
            end
        end
    end

    assign wbE_out    = wb_e;
    assign wbIdx_out  = wb_idx;
    assign wbData_out = wb_data;

    ex_wb_regfile_read_port #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM),
        .IDX_W   (IDX_W)
    ) u_rs1 (
        .rs_e    (rs1E_in),
        .rs_idx  (rs1Idx_in),
        .regs    (regs),
`ifdef REGFILE_BYPASS_EN
        .wb_e    (wb_e),
        .wb_idx  (wb_idx),
        .wb_data (wb_data),
`endif
        .rs_data (rs1Data_out)
    );

    ex_wb_regfile_read_port #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM),
        .IDX_W   (IDX_W)
    ) u_rs2 (
        .rs_e    (rs2E_in),
        .rs_idx  (rs2Idx_in),
        .regs    (regs),
`ifdef REGFILE_BYPASS_EN
        .wb_e    (wb_e),
        .wb_idx  (wb_idx),
        .wb_data (wb_data),
`endif
        .rs_data (rs2Data_out)
    );

endmodule

// File: tb/tb_ex_wb_regfile.sv
// Bench for ex_wb_regfile: directed scenarios then random traffic against
// an architectural model (committed array plus one pending write).
module tb_ex_wb_regfile;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        stall_in;
    logic        flush_in;
    logic        rdE_in;
    logic [4:0]  rdIdx_in;
    logic [31:0] rdData_in;
    logic        rs1E_in;
    logic [4:0]  rs1Idx_in;
    logic        rs2E_in;
    logic [4:0]  rs2Idx_in;
    logic [31:0] rs1Data_out;
    logic [31:0] rs2Data_out;
    logic        wbE_out;
    logic [4:0]  wbIdx_out;
    logic [31:0] wbData_out;

    int n_cmp = 0;
    int n_err = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // architectural model
    logic [31:0] m_regs [32];
    logic        m_e;
    logic [4:0]  m_idx;
    logic [31:0] m_data;

    ex_wb_regfile dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .stall_in    (stall_in),
        .flush_in    (flush_in),
        .rdE_in      (rdE_in),
        .rdIdx_in    (rdIdx_in),
        .rdData_in   (rdData_in),
        .rs1E_in     (rs1E_in),
        .rs1Idx_in   (rs1Idx_in),
        .rs2E_in     (rs2E_in),
        .rs2Idx_in   (rs2Idx_in),
        .rs1Data_out (rs1Data_out),
        .rs2Data_out (rs2Data_out),
        .wbE_out     (wbE_out),
        .wbIdx_out   (wbIdx_out),
        .wbData_out  (wbData_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic en,
                                           input logic [4:0] idx);
        if (!en || idx == 5'd0) return 32'h0;
        if (BYPASS && m_e && m_idx == idx) return m_data;
        return m_regs[idx];
    endfunction

    task automatic model_edge();
        if (rst_in) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_e = 1'b0;
            m_idx = 5'd0;
            m_data = 32'h0;
        end else begin
            if (m_e) m_regs[m_idx] = m_data;
            if (flush_in) begin
                m_e = 1'b0;
            end else if (!stall_in) begin
                m_e = rdE_in && (rdIdx_in != 5'd0);
                m_idx = rdIdx_in;
                m_data = rdData_in;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic compare_all(input string tag);
        #1;
        check({tag, ".wbE"}, {31'd0, wbE_out}, {31'd0, m_e});
        if (m_e) begin
            check({tag, ".wbIdx"}, {27'd0, wbIdx_out}, {27'd0, m_idx});
            check({tag, ".wbData"}, wbData_out, m_data);
        end
        check({tag, ".rs1"}, rs1Data_out, exp_rd(rs1E_in, rs1Idx_in));
        check({tag, ".rs2"}, rs2Data_out, exp_rd(rs2E_in, rs2Idx_in));
    endtask

    task automatic idle_inputs();
        rst_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
        rdE_in = 1'b0; rdIdx_in = 5'd0; rdData_in = 32'h0;
        rs1E_in = 1'b0; rs1Idx_in = 5'd0;
        rs2E_in = 1'b0; rs2Idx_in = 5'd0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'hx;
        m_e = 1'bx; m_idx = 5'hx; m_data = 32'hx;

        // reset with every input nonzero
        rst_in = 1'b1; stall_in = 1'b1; flush_in = 1'b1;
        rdE_in = 1'b1; rdIdx_in = 5'd5; rdData_in = 32'hFFFF_FFFF;
        rs1E_in = 1'b1; rs1Idx_in = 5'd3;
        rs2E_in = 1'b1; rs2Idx_in = 5'd31;
        tick(); tick();
        check("rst.wbE", {31'd0, wbE_out}, 32'h0);
        check("rst.wbIdx", {27'd0, wbIdx_out}, 32'h0);
        check("rst.wbData", wbData_out, 32'h0);
        idle_inputs();
        rs1E_in = 1'b1; rs2E_in = 1'b1;
        for (int i = 1; i < 32; i++) begin
            rs1Idx_in = i[4:0];
            rs2Idx_in = 5'(32 - i);
            #1;
            check("rst.rd1", rs1Data_out, 32'h0);
            check("rst.rd2", rs2Data_out, 32'h0);
        end

        // x5 latency: bypass vs array-only
        idle_inputs();
        rdE_in = 1'b1; rdIdx_in = 5'd5; rdData_in = 32'hDEAD_BEEF;
        tick();
        rdE_in = 1'b0; rs1E_in = 1'b1; rs1Idx_in = 5'd5;
        #1;
        check("x5.n1", rs1Data_out, BYPASS ? 32'hDEAD_BEEF : 32'h0);
        check("x5.wbData", wbData_out, 32'hDEAD_BEEF);
        tick();
        check("x5.n2", rs1Data_out, 32'hDEAD_BEEF);
        compare_all("x5");

        // x0 is never written
        idle_inputs();
        rdE_in = 1'b1; rdIdx_in = 5'd0; rdData_in = 32'h1234_5678;
        tick();
        check("x0.wbE", {31'd0, wbE_out}, 32'h0);
        rdE_in = 1'b0; rs1E_in = 1'b1; rs2E_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("x0.rd1", rs1Data_out, 32'h0);
            check("x0.rd2", rs2Data_out, 32'h0);
            tick();
        end

        // stall holds x7 = 1 while x7 = 2 waits upstream
        idle_inputs();
        rdE_in = 1'b1; rdIdx_in = 5'd7; rdData_in = 32'h1;
        tick();
        stall_in = 1'b1; rdData_in = 32'h2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.wbData", wbData_out, 32'h1);
            check("stall.wbE", {31'd0, wbE_out}, 32'h1);
        end
        stall_in = 1'b0;
        tick();
        check("stall.rel", wbData_out, 32'h2);
        rdE_in = 1'b0;
        tick();
        rs1E_in = 1'b1; rs1Idx_in = 5'd7;
        #1;
        check("stall.commit", rs1Data_out, 32'h2);

        // flush beats stall
        idle_inputs();
        rdE_in = 1'b1; rdIdx_in = 5'd9; rdData_in = 32'hAA;
        flush_in = 1'b1; stall_in = 1'b1;
        tick();
        check("flush.wbE", {31'd0, wbE_out}, 32'h0);
        idle_inputs();
        tick();
        rs1E_in = 1'b1; rs1Idx_in = 5'd9;
        #1;
        check("flush.x9", rs1Data_out, 32'h0);

        // back-to-back writes to x3
        idle_inputs();
        rdE_in = 1'b1; rdIdx_in = 5'd3; rdData_in = 32'h11;
        tick();
        rdData_in = 32'h22;
        tick();
        rdE_in = 1'b0;
        rs1E_in = 1'b1; rs1Idx_in = 5'd3;
        rs2E_in = 1'b1; rs2Idx_in = 5'd3;
        #1;
        check("b2b.rs1", rs1Data_out, BYPASS ? 32'h22 : 32'h11);
        check("b2b.rs2", rs2Data_out, BYPASS ? 32'h22 : 32'h11);
        tick();
        check("b2b.arr1", rs1Data_out, 32'h22);
        check("b2b.arr2", rs2Data_out, 32'h22);

        // reset mid-operation discards the pending write
        idle_inputs();
        rdE_in = 1'b1; rdIdx_in = 5'd10; rdData_in = 32'h55;
        tick();
        rst_in = 1'b1; rdE_in = 1'b0;
        tick();
        rst_in = 1'b0;
        rs1E_in = 1'b1; rs1Idx_in = 5'd10;
        rs2E_in = 1'b1; rs2Idx_in = 5'd3;
        #1;
        check("midrst.x10", rs1Data_out, 32'h0);
        check("midrst.x3", rs2Data_out, 32'h0);
        tick();
        check("midrst.x10b", rs1Data_out, 32'h0);

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst_in    = ($urandom_range(0, 59) == 0);
            stall_in  = ($urandom_range(0, 4) == 0);
            flush_in  = ($urandom_range(0, 7) == 0);
            rdE_in    = ($urandom_range(0, 3) != 0);
            rdIdx_in  = 5'($urandom_range(0, 7));
            rdData_in = $urandom;
            rs1E_in   = ($urandom_range(0, 7) != 0);
            rs1Idx_in = 5'($urandom_range(0, 7));
            rs2E_in   = ($urandom_range(0, 7) != 0);
            rs2Idx_in = ($urandom_range(0, 3) == 0) ? rs1Idx_in
                                                    : 5'($urandom_range(0, 31));
            compare_all("rnd");
            if (rs1E_in && rs2E_in && rs1Idx_in == rs2Idx_in)
                check("rnd.same", rs1Data_out, rs2Data_out);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
